pmt_master_cmd_rx: RTL and testbench

Receiving end of the PMT master write stream. It consumes the `{valid, first}` word stream produced by the PMT master selector, parses the header word, and issues indexed payload writes to the per-channel PMT command logic. It drives the 4-bit per-channel `cmd_parser` busy mask back to the selector, which gates and terminates that selector's write window, and it aborts frames on timeout or on a truncated frame.

---
 rtl/pmt_cmd_defs.sv | 51 +++++
 rtl/pmt_cmd_timeout.sv | 51 +++++
 rtl/pmt_master_cmd_rx.sv | 217 +++++++++++++++++++++
 tb/tb_pmt_master_cmd_rx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmt_cmd_defs.sv
// ---------------------------------------------------------------------------
// pmt_cmd_defs
//   Definitions shared by the PMT master selector, the master command
//   receiver and the per-channel PMT command logic.
//   Contents:
//     - header field positions (opcode, channel mask, payload length)
//     - {valid, first} stream qualifier encodings
//     - abort reason codes
//     - receiver FSM state encoding
//     - default idle timeout between words of one frame
//     - helpers that pull the header fields out of a stream word
// ---------------------------------------------------------------------------
package pmt_cmd_defs;

  // Header word layout; bits [31:16] carry no meaning.
  localparam int HDR_OPC_MSB  = 15;
  localparam int HDR_OPC_LSB  = 12;
  localparam int HDR_MASK_MSB = 11;
  localparam int HDR_MASK_LSB = 8;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 0;

  // Stream qualifier: bit1 = word valid, bit0 = first word of frame.
  localparam logic [1:0] VLD_HDR = 2'b11;
  localparam logic [1:0] VLD_PAY = 2'b10;

  // Abort reasons reported alongside cmd_err_o.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_TRUNC   = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 32768;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } rx_state_e;

  function automatic logic [3:0] hdr_opcode(input logic [31:0] w);
    return w[HDR_OPC_MSB:HDR_OPC_LSB];
  endfunction

  function automatic logic [3:0] hdr_mask(input logic [31:0] w);
    return w[HDR_MASK_MSB:HDR_MASK_LSB];
  endfunction

  function automatic logic [7:0] hdr_len(input logic [31:0] w);
    return w[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/pmt_cmd_timeout.sv
// ---------------------------------------------------------------------------
// pmt_cmd_timeout
//   Saturating idle counter guarding the gap between words of one frame.
//   Ports:
//     clk_i     clock
//     rst_i     synchronous active-high reset
//     clr_i     restart the count (word accepted, or no frame open)
//     en_i      count this cycle as idle
//     expire_o  single-cycle pulse in the idle cycle that brings the count
//               to TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module pmt_cmd_timeout
  import pmt_cmd_defs::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt_d, cnt_q;

  // The counter parks at CNT_LAST, so the compare against CNT_PRE can only
  // fire once per run of idle cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_q == CNT_PRE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pmt_master_cmd_rx.sv
// ---------------------------------------------------------------------------
// pmt_master_cmd_rx
//   Receiving end of the PMT master write stream. Parses the header word,
//   issues indexed payload writes to the per-channel command logic, reports
//   completion or abort, and drives the per-channel busy mask back to the
//   selector.
//   Ports:
//     clk_i                    clock
//     rst_i                    synchronous active-high reset
//     pmt_master_wr_data_i     stream word
//     pmt_master_wr_vld_i      {valid, first}; 2'b11 header, 2'b10 payload
//     pmt_master_cmd_parser_o  busy mask (header channel mask while open)
//     cmd_opcode_o             opcode of the current frame
//     cmd_chan_o               channel mask of the current frame
//     cmd_addr_o               payload word index
//     cmd_data_o               payload word
//     cmd_vld_o                strobe: cmd_addr_o/cmd_data_o valid
//     cmd_done_o               strobe: frame completed
//     cmd_err_o                strobe: frame aborted
//     cmd_err_code_o           abort reason, valid with cmd_err_o
// ---------------------------------------------------------------------------
module pmt_master_cmd_rx
  import pmt_cmd_defs::*;
#(
  parameter real TCQ            = 0.1,
  parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pmt_master_wr_data_i,
  input  logic [1:0]  pmt_master_wr_vld_i,
  output logic [3:0]  pmt_master_cmd_parser_o,
  output logic [3:0]  cmd_opcode_o,
  output logic [3:0]  cmd_chan_o,
  output logic [7:0]  cmd_addr_o,
  output logic [31:0] cmd_data_o,
  output logic        cmd_vld_o,
  output logic        cmd_done_o,
  output logic        cmd_err_o,
  output logic [1:0]  cmd_err_code_o
);

  // TCQ only models clock-to-Q in behavioural copies of this block; it has
  // no effect on the logic here, but a nonsense value is still rejected.
  if ((TIMEOUT_CYCLES < 2) || (TCQ < 0.0)) begin : g_bad_param
    $error("pmt_master_cmd_rx: TIMEOUT_CYCLES must be >= 2 and TCQ >= 0");
  end

  rx_state_e   state_d, state_q;
  logic [3:0]  opc_d, opc_q;
  logic [3:0]  mask_d, mask_q;
  logic [7:0]  len_d, len_q;
  logic [7:0]  idx_d, idx_q;

  logic [3:0]  busy_d, busy_q;
  logic [3:0]  cmd_opcode_d, cmd_opcode_q;
  logic [3:0]  cmd_chan_d, cmd_chan_q;
  logic [7:0]  cmd_addr_d, cmd_addr_q;
  logic [31:0] cmd_data_d, cmd_data_q;
  logic        cmd_vld_d, cmd_vld_q;
  logic        cmd_done_d, cmd_done_q;
  logic        cmd_err_d, cmd_err_q;
  logic [1:0]  cmd_err_code_d, cmd_err_code_q;

  logic        is_hdr, is_pay, word_acc;
  logic        hdr_take;
  logic        to_clr, to_en, to_expire;
  logic [3:0]  in_opc, in_mask;
  logic [7:0]  in_len;

  assign is_hdr   = (pmt_master_wr_vld_i == VLD_HDR);
  assign is_pay   = (pmt_master_wr_vld_i == VLD_PAY);
  assign word_acc = is_hdr || is_pay;

  assign in_opc  = hdr_opcode(pmt_master_wr_data_i);
  assign in_mask = hdr_mask(pmt_master_wr_data_i);
  assign in_len  = hdr_len(pmt_master_wr_data_i);

  // The idle count only runs while a frame is open and nothing arrives.
  assign to_clr = (state_q != ST_PAYLOAD) || word_acc;
  assign to_en  = (state_q == ST_PAYLOAD) && !word_acc;

  pmt_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (to_clr),
    .en_i    (to_en),
    .expire_o(to_expire)
  );

  // Next-state and next-output computation. A header seen mid-frame first
  // aborts the open frame and is then handled by the same header path used
  // from IDLE, so the interrupting frame starts without losing a word.
  always_comb begin
    state_d        = state_q;
    opc_d          = opc_q;
    mask_d         = mask_q;
    len_d          = len_q;
    idx_d          = idx_q;
    cmd_opcode_d   = cmd_opcode_q;
    cmd_chan_d     = cmd_chan_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_data_d     = cmd_data_q;
    cmd_vld_d      = 1'b0;
    cmd_done_d     = 1'b0;
    cmd_err_d      = 1'b0;
    cmd_err_code_d = ERR_NONE;
    hdr_take       = 1'b0;
    busy_d         = 4'h0;

    unique case (state_q)
      ST_IDLE: begin
        hdr_take = is_hdr;
      end
      ST_PAYLOAD: begin
        if (is_hdr) begin
          cmd_err_d      = 1'b1;
          cmd_err_code_d = ERR_TRUNC;
          state_d        = ST_IDLE;
          hdr_take       = 1'b1;
        end else if (is_pay) begin
          cmd_vld_d  = 1'b1;
          cmd_addr_d = idx_q;
          cmd_data_d = pmt_master_wr_data_i;
          idx_d      = idx_q + 8'd1;
          // Frame identity becomes visible with its first write.
          if (idx_q == 8'd0) begin
            cmd_opcode_d = opc_q;
            cmd_chan_d   = mask_q;
          end
          if (idx_q == (len_q - 8'd1)) begin
            cmd_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (to_expire) begin
          cmd_err_d      = 1'b1;
          cmd_err_code_d = ERR_TIMEOUT;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A header addressing no channel is dropped entirely.
    if (hdr_take && (in_mask != 4'h0)) begin
      opc_d  = in_opc;
      mask_d = in_mask;
      len_d  = in_len;
      idx_d  = 8'd0;
      if (in_len == 8'd0) begin
        cmd_done_d   = 1'b1;
        cmd_opcode_d = in_opc;
        cmd_chan_d   = in_mask;
        state_d      = ST_IDLE;
      end else begin
        state_d = ST_PAYLOAD;
      end
    end

    // Busy stays up through the done/err cycle so the selector closes its
    // window one cycle after the terminating strobe; a zero-length frame
    // therefore shows busy for exactly its done cycle.
    if ((state_d == ST_PAYLOAD) || cmd_done_d || cmd_err_d) begin
      busy_d = mask_d;
    end
  end

  // Single state/output register bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      opc_q          <= 4'h0;
      mask_q         <= 4'h0;
      len_q          <= 8'h00;
      idx_q          <= 8'h00;
      busy_q         <= 4'h0;
      cmd_opcode_q   <= 4'h0;
      cmd_chan_q     <= 4'h0;
      cmd_addr_q     <= 8'h00;
      cmd_data_q     <= 32'h0;
      cmd_vld_q      <= 1'b0;
      cmd_done_q     <= 1'b0;
      cmd_err_q      <= 1'b0;
      cmd_err_code_q <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      opc_q          <= opc_d;
      mask_q         <= mask_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      busy_q         <= busy_d;
      cmd_opcode_q   <= cmd_opcode_d;
      cmd_chan_q     <= cmd_chan_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_data_q     <= cmd_data_d;
      cmd_vld_q      <= cmd_vld_d;
      cmd_done_q     <= cmd_done_d;
      cmd_err_q      <= cmd_err_d;
      cmd_err_code_q <= cmd_err_code_d;
    end
  end

  assign pmt_master_cmd_parser_o = busy_q;
  assign cmd_opcode_o            = cmd_opcode_q;
  assign cmd_chan_o              = cmd_chan_q;
  assign cmd_addr_o              = cmd_addr_q;
  assign cmd_data_o              = cmd_data_q;
  assign cmd_vld_o               = cmd_vld_q;
  assign cmd_done_o              = cmd_done_q;
  assign cmd_err_o               = cmd_err_q;
  assign cmd_err_code_o          = cmd_err_code_q;

endmodule

// File: tb/tb_pmt_master_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_pmt_master_cmd_rx
//   Directed bench for pmt_master_cmd_rx with a short idle timeout.
// ---------------------------------------------------------------------------
module tb_pmt_master_cmd_rx;

  localparam int TO_CYCLES = 16;

  logic        clk;
  logic        rst;
  logic [31:0] wr_data;
  logic [1:0]  wr_vld;
  logic [3:0]  busy;
  logic [3:0]  opcode;
  logic [3:0]  chan;
  logic [7:0]  addr;
  logic [31:0] data;
  logic        vld;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  // Strobe view: {busy[3:0], vld, done, err, err_code[1:0]}
  logic [8:0]  strb;
  assign strb = {busy, vld, done, err, err_code};

  int checks;
  int errors;

  pmt_master_cmd_rx #(
    .TCQ           (0.1),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .pmt_master_wr_data_i   (wr_data),
    .pmt_master_wr_vld_i    (wr_vld),
    .pmt_master_cmd_parser_o(busy),
    .cmd_opcode_o           (opcode),
    .cmd_chan_o             (chan),
    .cmd_addr_o             (addr),
    .cmd_data_o             (data),
    .cmd_vld_o              (vld),
    .cmd_done_o             (done),
    .cmd_err_o              (err),
    .cmd_err_code_o         (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one stream word, let the DUT sample it, and return 1 ns after the
  // edge so the registered response to that word is visible.
  task automatic step(input logic [1:0] v, input logic [31:0] d);
    wr_vld  = v;
    wr_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2'b00, 32'h0);
    step(2'b11, 32'h0000_3203);
    rst = 1'b0;
    checks++;
    if (strb !== 9'h000) begin
      errors++;
      $display("[TB] FAIL reset.strobes got %b want %b", strb, 9'h000);
    end
    checks++;
    if ({opcode, chan, addr, data} !== 48'h0) begin
      errors++;
      $display("[TB] FAIL reset.fields got %h want %h", {opcode, chan, addr, data}, 48'h0);
    end
  endtask

  task automatic test_normal_frame();
    step(2'b11, 32'h0000_3203);
    checks++;
    if ({strb, opcode, chan} !== {4'h2, 5'b0_0_0_00, 4'h0, 4'h0}) begin
      errors++;
      $display("[TB] FAIL normal.hdr got %b/%h/%h want busy=2 opcode=0 chan=0", strb, opcode, chan);
    end
    step(2'b10, 32'h0000_000A);
    checks++;
    if ({strb, opcode, chan, addr, data} !== {4'h2, 5'b1_0_0_00, 4'h3, 4'h2, 8'd0, 32'hA}) begin
      errors++;
      $display("[TB] FAIL normal.w0 got %b op=%h ch=%h a=%0d d=%h want vld op=3 ch=2 a=0 d=a", strb, opcode, chan, addr, data);
    end
    step(2'b10, 32'h0000_000B);
    checks++;
    if ({strb, addr, data} !== {4'h2, 5'b1_0_0_00, 8'd1, 32'hB}) begin
      errors++;
      $display("[TB] FAIL normal.w1 got %b a=%0d d=%h want vld a=1 d=b", strb, addr, data);
    end
    step(2'b10, 32'h0000_000C);
    checks++;
    if ({strb, addr, data} !== {4'h2, 5'b1_1_0_00, 8'd2, 32'hC}) begin
      errors++;
      $display("[TB] FAIL normal.w2 got %b a=%0d d=%h want vld+done a=2 d=c", strb, addr, data);
    end
    step(2'b00, 32'h0);
    checks++;
    if ({strb, opcode, chan} !== {9'h000, 4'h3, 4'h2}) begin
      errors++;
      $display("[TB] FAIL normal.close got %b/%h/%h want busy=0 opcode=3 chan=2", strb, opcode, chan);
    end
  endtask

  task automatic test_zero_len();
    step(2'b11, 32'h0000_1F00);
    checks++;
    if ({strb, opcode, chan} !== {4'hF, 5'b0_1_0_00, 4'h1, 4'hF}) begin
      errors++;
      $display("[TB] FAIL zero.hdr got %b/%h/%h want busy=f done opcode=1 chan=f", strb, opcode, chan);
    end
    step(2'b00, 32'h0);
    checks++;
    if (strb !== 9'h000) begin
      errors++;
      $display("[TB] FAIL zero.close got %b want %b", strb, 9'h000);
    end
  endtask

  task automatic test_truncated();
    step(2'b11, 32'h0000_4704);
    step(2'b10, 32'h0000_0011);
    step(2'b10, 32'h0000_0022);
    checks++;
    if ({strb, addr, opcode} !== {4'h7, 5'b1_0_0_00, 8'd1, 4'h4}) begin
      errors++;
      $display("[TB] FAIL trunc.w1 got %b a=%0d op=%h want busy=7 vld a=1 op=4", strb, addr, opcode);
    end
    step(2'b11, 32'h0000_5102);
    checks++;
    if ({strb, opcode} !== {4'h1, 5'b0_0_1_10, 4'h4}) begin
      errors++;
      $display("[TB] FAIL trunc.abort got %b op=%h want busy=1 err code=2 op=4", strb, opcode);
    end
    step(2'b10, 32'h0000_0033);
    checks++;
    if ({strb, opcode, chan, addr, data} !== {4'h1, 5'b1_0_0_00, 4'h5, 4'h1, 8'd0, 32'h33}) begin
      errors++;
      $display("[TB] FAIL trunc.n0 got %b op=%h ch=%h a=%0d d=%h want vld op=5 ch=1 a=0 d=33", strb, opcode, chan, addr, data);
    end
    step(2'b10, 32'h0000_0044);
    checks++;
    if ({strb, addr, data} !== {4'h1, 5'b1_1_0_00, 8'd1, 32'h44}) begin
      errors++;
      $display("[TB] FAIL trunc.n1 got %b a=%0d d=%h want vld+done a=1 d=44", strb, addr, data);
    end
  endtask

  task automatic test_back_to_back();
    step(2'b11, 32'h0000_2301);
    step(2'b10, 32'h0000_0055);
    checks++;
    if ({strb, opcode, chan, addr} !== {4'h3, 5'b1_1_0_00, 4'h2, 4'h3, 8'd0}) begin
      errors++;
      $display("[TB] FAIL b2b.single got %b op=%h ch=%h a=%0d want vld+done op=2 ch=3 a=0", strb, opcode, chan, addr);
    end
    step(2'b11, 32'h0000_6402);
    checks++;
    if (strb !== {4'h4, 5'b0_0_0_00}) begin
      errors++;
      $display("[TB] FAIL b2b.hdr got %b want busy=4 no strobes", strb);
    end
    step(2'b10, 32'h0000_0066);
    checks++;
    if ({strb, opcode, addr} !== {4'h4, 5'b1_0_0_00, 4'h6, 8'd0}) begin
      errors++;
      $display("[TB] FAIL b2b.w0 got %b op=%h a=%0d want vld op=6 a=0", strb, opcode, addr);
    end
    step(2'b11, 32'h0000_7800);
    checks++;
    if ({strb, opcode, chan} !== {4'h8, 5'b0_1_1_10, 4'h7, 4'h8}) begin
      errors++;
      $display("[TB] FAIL b2b.errdone got %b op=%h ch=%h want busy=8 done+err code=2 op=7 ch=8", strb, opcode, chan);
    end
    step(2'b00, 32'h0);
    checks++;
    if (strb !== 9'h000) begin
      errors++;
      $display("[TB] FAIL b2b.close got %b want %b", strb, 9'h000);
    end
  endtask

  task automatic test_timeout();
    logic [8:0] want;
    step(2'b11, 32'h0000_9A02);
    step(2'b10, 32'h0000_0077);
    checks++;
    if ({strb, opcode, chan} !== {4'hA, 5'b1_0_0_00, 4'h9, 4'hA}) begin
      errors++;
      $display("[TB] FAIL timeout.w0 got %b op=%h ch=%h want busy=a vld op=9 ch=a", strb, opcode, chan);
    end
    for (int i = 1; i <= TO_CYCLES - 1; i++) begin
      step((i % 3 == 0) ? 2'b01 : 2'b00, 32'h0000_1234);
      want = (i == TO_CYCLES - 1) ? {4'hA, 5'b0_0_1_01} : {4'hA, 5'b0_0_0_00};
      checks++;
      if (strb !== want) begin
        errors++;
        $display("[TB] FAIL timeout.idle%0d got %b want %b", i, strb, want);
      end
    end
    step(2'b00, 32'h0);
    checks++;
    if (strb !== 9'h000) begin
      errors++;
      $display("[TB] FAIL timeout.close got %b want %b", strb, 9'h000);
    end
  endtask

  task automatic test_ignored();
    step(2'b11, 32'h0000_30F5);
    checks++;
    if ({strb, opcode, chan} !== {9'h000, 4'h9, 4'hA}) begin
      errors++;
      $display("[TB] FAIL ignore.mask0 got %b op=%h ch=%h want quiet op=9 ch=a", strb, opcode, chan);
    end
    step(2'b10, 32'h0000_DEAD);
    checks++;
    if ({strb, data} !== {9'h000, 32'h0000_0077}) begin
      errors++;
      $display("[TB] FAIL ignore.stray got %b d=%h want quiet d=77", strb, data);
    end
    step(2'b01, 32'h0000_1105);
    step(2'b00, 32'h0);
    checks++;
    if ({strb, opcode} !== {9'h000, 4'h9}) begin
      errors++;
      $display("[TB] FAIL ignore.vld01 got %b op=%h want quiet op=9", strb, opcode);
    end
  endtask

  task automatic test_reset_midframe();
    step(2'b11, 32'h0000_B808);
    step(2'b10, 32'h0000_0001);
    step(2'b10, 32'h0000_0002);
    checks++;
    if ({strb, opcode, addr} !== {4'h8, 5'b1_0_0_00, 4'hB, 8'd1}) begin
      errors++;
      $display("[TB] FAIL rstmid.w1 got %b op=%h a=%0d want busy=8 vld op=b a=1", strb, opcode, addr);
    end
    rst = 1'b1;
    step(2'b10, 32'h0000_0003);
    rst = 1'b0;
    checks++;
    if ({strb, opcode, chan, addr, data} !== 57'h0) begin
      errors++;
      $display("[TB] FAIL rstmid.clear got %b op=%h ch=%h a=%0d d=%h want all 0", strb, opcode, chan, addr, data);
    end
    step(2'b10, 32'h0000_0004);
    checks++;
    if (strb !== 9'h000) begin
      errors++;
      $display("[TB] FAIL rstmid.quiet got %b want %b", strb, 9'h000);
    end
    step(2'b11, 32'h0000_C101);
    checks++;
    if (strb !== {4'h1, 5'b0_0_0_00}) begin
      errors++;
      $display("[TB] FAIL rstmid.newhdr got %b want busy=1", strb);
    end
    step(2'b10, 32'h0000_0099);
    checks++;
    if ({strb, opcode, chan, addr, data} !== {4'h1, 5'b1_1_0_00, 4'hC, 4'h1, 8'd0, 32'h99}) begin
      errors++;
      $display("[TB] FAIL rstmid.newfrm got %b op=%h ch=%h a=%0d d=%h want vld+done op=c ch=1 a=0 d=99", strb, opcode, chan, addr, data);
    end
    step(2'b00, 32'h0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    wr_vld  = 2'b00;
    wr_data = 32'h0;
    test_reset();
    test_normal_frame();
    test_zero_len();
    test_truncated();
    test_back_to_back();
    test_timeout();
    test_ignored();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
